// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared widths, state enum and byte-tag encoding for mem_bus_ctrl
package mem_bus_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_WR_LO,
        ST_WR_HI,
        ST_RD_LO,
        ST_RD_HI,
        ST_DONE,
        ST_HALTED
    } state_e;

    // One-hot byte tag, bit order {bus_mdr, bus_mar, bus_pc}
    typedef enum logic [2:0] {
        TAG_NONE = 3'b000,
        TAG_PC   = 3'b001,
        TAG_MAR  = 3'b010,
        TAG_MDR  = 3'b100
    } tag_e;

endpackage

// File: rtl/mem_bus_timeout.sv
// rtl/mem_bus_timeout.sv - per-byte stall counter with expiry flag
module mem_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // expired is high during the TIMEOUT_CYCLES-th consecutive stalled cycle
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - serializes 16-bit CPU requests into tagged Arduino bytes; optional stall timeout via MEM_BUS_TIMEOUT_EN
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_fetch,
    input  logic [WORD_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    input  logic              cpu_halt,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [WORD_W-1:0] cpu_rdata,
    input  logic              ard_receive_ready,
    input  logic              ard_data_ready,
    input  logic [BYTE_W-1:0] in_bus,
    output logic [BYTE_W-1:0] out_bus,
    output logic              bus_pc,
    output logic              bus_mar,
    output logic              bus_mdr,
    output logic              bus_wr,
    output logic              halt
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e            state_q, state_d;
    logic              we_q, we_d, fetch_q, fetch_d;
    logic              pend_q, pend_d, err_q, err_d;
    logic [WORD_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [BYTE_W-1:0] rdbuf_q, rdbuf_d;
    logic              byte_state, stall_expired;
    tag_e              tag;

    assign byte_state = state_q inside {ST_ADDR_LO, ST_ADDR_HI, ST_WR_LO, ST_WR_HI, ST_RD_LO, ST_RD_HI};

`ifdef MEM_BUS_TIMEOUT_EN
    logic state_chg;
    assign state_chg = (state_d != state_q);

    mem_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .count_en (byte_state),
        .clear    (state_chg),
        .expired  (stall_expired)
    );
`else
    assign stall_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        fetch_d = fetch_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rdbuf_d = rdbuf_q;
        pend_d  = pend_q;
        err_d   = 1'b0;

        if (state_q != ST_IDLE && cpu_halt) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cpu_halt) begin
                    state_d = ST_HALTED;
                end else if (cpu_req) begin
                    we_d    = cpu_we;
                    fetch_d = cpu_fetch;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO, ST_ADDR_HI, ST_WR_LO, ST_WR_HI: begin
                if (ard_receive_ready) begin
                    case (state_q)
                        ST_ADDR_LO: state_d = ST_ADDR_HI;
                        ST_ADDR_HI: state_d = we_q ? ST_WR_LO : ST_RD_LO;
                        ST_WR_LO:   state_d = ST_WR_HI;
                        default:    state_d = ST_DONE;
                    endcase
                end else if (stall_expired) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_RD_LO, ST_RD_HI: begin
                if (ard_data_ready) begin
                    if (state_q == ST_RD_LO) begin
                        rdbuf_d = in_bus;
                        state_d = ST_RD_HI;
                    end else begin
                        rdata_d = {in_bus, rdbuf_q};
                        state_d = ST_DONE;
                    end
                end else if (stall_expired) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_DONE:   state_d = (pend_q || cpu_halt) ? ST_HALTED : ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            fetch_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rdbuf_q <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            fetch_q <= fetch_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rdbuf_q <= rdbuf_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs depend only on registered state and captured request fields
    always_comb begin
        tag     = TAG_NONE;
        out_bus = '0;
        case (state_q)
            ST_ADDR_LO: begin tag = fetch_q ? TAG_PC : TAG_MAR; out_bus = addr_q[7:0];   end
            ST_ADDR_HI: begin tag = fetch_q ? TAG_PC : TAG_MAR; out_bus = addr_q[15:8];  end
            ST_WR_LO:   begin tag = TAG_MDR;                    out_bus = wdata_q[7:0];  end
            ST_WR_HI:   begin tag = TAG_MDR;                    out_bus = wdata_q[15:8]; end
            default:    begin tag = TAG_NONE;                   out_bus = '0;            end
        endcase
    end

    assign {bus_mdr, bus_mar, bus_pc} = tag;
    assign bus_wr    = we_q && (state_q inside {ST_ADDR_LO, ST_ADDR_HI, ST_WR_LO, ST_WR_HI});
    assign cpu_ack   = (state_q == ST_DONE);
    assign cpu_err   = err_q;
    assign cpu_rdata = rdata_q;
    assign halt      = (state_q == ST_HALTED);

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Sequencer for the serial CPU's external byte bus. It accepts one 16-bit read or write request at a time from `cpu_core` and serializes it into tagged 8-bit transfers to the Arduino: address bytes tagged `bus_pc` or `bus_mar`, then data bytes tagged `bus_mdr`, using the `ard_receive_ready`/`ard_data_ready` handshakes. It returns read data and a completion pulse to the core, and it owns the chip-level `halt` indication.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: stall limit per byte. Used only with `MEM_BUS_TIMEOUT_EN`. Must be at least 2.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `cpu_req` input 1: transfer request. Sampled only in IDLE.
- `cpu_we` input 1: 1 = write, 0 = read. Captured with the request.
- `cpu_fetch` input 1: 1 = instruction fetch (PC address), 0 = data access. Captured with the request.
- `cpu_addr` input 16: word address. Captured with the request.
- `cpu_wdata` input 16: write data. Captured with the request.
- `cpu_halt` input 1: core requests halt.
- `cpu_ack` output 1: one-cycle completion pulse.
- `cpu_err` output 1: high with `cpu_ack` when the transfer timed out.
- `cpu_rdata` output 16: read data. Updated only when a read completes without error, then held.
- `ard_receive_ready` input 1: Arduino accepts the outgoing byte this cycle.
- `ard_data_ready` input 1: `in_bus` carries a valid byte this cycle.
- `in_bus` input 8: byte from the Arduino.
- `out_bus` output 8: byte to the Arduino.
- `bus_pc`, `bus_mar`, `bus_mdr` output 1 each: byte tags. At most one is high. Any tag high means `out_bus` is valid.
- `bus_wr` output 1: high during every byte of a write transaction.
- `halt` output 1: processor halted.

## Operation
- States: IDLE, ADDR_LO, ADDR_HI, WR_LO, WR_HI, RD_LO, RD_HI, DONE, HALTED.
- IDLE:
  - If `cpu_halt` is high, go to HALTED. A simultaneous `cpu_req` is dropped with no ack.
  - Otherwise, if `cpu_req` is high, capture `we`, `fetch`, `addr` and `wdata`, then go to ADDR_LO.
- ADDR_LO / ADDR_HI:
  - Drive `out_bus` with `addr[7:0]` / `addr[15:8]`.
  - Tag is `bus_pc` if `fetch`, else `bus_mar`.
  - Advance on a cycle with `ard_receive_ready` high.
  - After ADDR_HI, go to WR_LO if `we`, else RD_LO.
- WR_LO / WR_HI:
  - Drive `wdata[7:0]` / `wdata[15:8]` with tag `bus_mdr`.
  - Advance on `ard_receive_ready`. WR_HI goes to DONE.
- RD_LO / RD_HI:
  - No tag asserted and `out_bus` = 0.
  - On `ard_data_ready`, capture `in_bus` into the low / high byte of an internal buffer and advance. RD_HI goes to DONE.
  - `cpu_rdata` loads the full buffer on the RD_HI→DONE edge.
- DONE:
  - `cpu_ack` = 1 for exactly this cycle.
  - Go to HALTED if a halt is pending, else IDLE.
- Halt during a transaction:
  - `cpu_halt` seen in any non-IDLE state sets a sticky pending flag.
  - The transaction completes normally, then the block enters HALTED.
- HALTED: `halt` = 1. All requests are ignored. Exit only by `rst`.
- Outside the byte states, handshake inputs are ignored:
  - `ard_receive_ready` is ignored when no tag is driven.
  - `ard_data_ready` is ignored outside RD_LO/RD_HI.
- `cpu_req` is ignored outside IDLE. A request still high in the cycle after `cpu_ack` starts a new transaction.

## Timing
- Reset values:
  - State IDLE.
  - `cpu_ack`, `cpu_err`, all tags, `bus_wr` and `halt` = 0.
  - `out_bus` = 0 and `cpu_rdata` = 0.
  - Pending-halt flag and timeout counter cleared.
- Reset mid-transaction aborts immediately: no ack, no further bus bytes.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- Zero-wait latency: request sampled at cycle 0 → byte states at cycles 1–4 → `cpu_ack` at cycle 5. This holds for both reads and writes.
- Each wait cycle on a handshake adds exactly one cycle. Tag, `out_bus` and `bus_wr` stay stable while waiting.

## Configuration
- `MEM_BUS_TIMEOUT_EN` defined:
  - A counter runs in each byte state and clears on every state change.
  - After `TIMEOUT_CYCLES` consecutive cycles without the handshake, go to DONE with `cpu_err` = 1.
  - `cpu_rdata` is not updated on a timed-out transfer.
- Not defined: the block waits indefinitely, and `cpu_err` is constant 0.

## Structure
- Package `mem_bus_pkg` holds:
  - The state enum.
  - `BYTE_W` = 8 and `WORD_W` = 16.
  - The tag one-hot encoding.
- Sub-module `mem_bus_timeout` holds the stall counter and its expiry flag. It is instantiated only under `MEM_BUS_TIMEOUT_EN`.

## Test plan
- Zero-wait write, addr 0x1234, data 0xBEEF, not a fetch:
  - Bytes 0x34, 0x12 tagged `bus_mar`, then 0xEF, 0xBE tagged `bus_mdr`, with `bus_wr` high throughout.
  - `cpu_ack` at cycle 5.
- Fetch read, addr 0x00A0, Arduino returns 0x5A then 0xC3 with 3 wait cycles before each:
  - Address bytes are tagged `bus_pc`.
  - `cpu_rdata` = 0xC35A.
  - `cpu_ack` at cycle 11.
- `ard_receive_ready` held low for 4 cycles during ADDR_HI:
  - Tag and `out_bus` stay stable.
  - No spurious RD capture from `ard_data_ready` pulses during that time.
- `cpu_halt` pulsed during WR_LO:
  - Write completes and ack fires.
  - `halt` = 1 the next cycle.
  - A later `cpu_req` gets no response.
- `rst` asserted in RD_HI:
  - All outputs return to reset values the next cycle, with no ack.
  - A new write then runs normally.
- With `MEM_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, Arduino silent during RD_LO:
  - `cpu_ack` and `cpu_err` both = 1.
  - `cpu_rdata` unchanged.
